// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/measure/publish sequencer for two HC-SR04 rangers
// sharing one echo-width datapath.
module sonar_scheduler #(
    parameter logic [21:0] TRIG_CYC    = 22'd500,
    parameter logic [18:0] TIMEOUT_CYC = 19'd480000,
    parameter logic [21:0] GAP_CYC     = 22'd3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  echo,
    output logic [1:0]  trig,
    output logic [18:0] pulse_num,
    output logic        pulse_vld,
    output logic        ch_id,
    output logic        timeout,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, PUB, GAP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  echo_m_q, echo_s_q, echo_p_q;
    logic        cur_ch_q, cur_ch_d;
    logic [21:0] cnt_q, cnt_d;
    logic [1:0]  trig_q, trig_d;
    logic [18:0] pulse_num_q, pulse_num_d;
    logic        pulse_vld_q, pulse_vld_d;
    logic        ch_id_q, ch_id_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;
    logic        echo_now, echo_rise;
    logic [21:0] tmo;

    assign tmo       = {3'b000, TIMEOUT_CYC};
    assign echo_now  = echo_s_q[cur_ch_q];
    // only a 0->1 transition seen while waiting counts, so a stuck-high echo times out
    assign echo_rise = echo_now & ~echo_p_q[cur_ch_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 22'd1;
        cur_ch_d    = cur_ch_q;
        trig_d      = trig_q;
        pulse_num_d = pulse_num_q;
        pulse_vld_d = 1'b0;
        ch_id_d     = ch_id_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = TRIG;
                    trig_d  = cur_ch_q ? 2'b10 : 2'b01;
                end
            end
            TRIG: if (cnt_q == TRIG_CYC - 22'd1) begin
                state_d = WAIT;
                cnt_d   = '0;
                trig_d  = 2'b00;
            end
            WAIT: begin
                if (echo_rise) begin
                    state_d = MEAS;
                    cnt_d   = '0;
                end else if (cnt_q == tmo) begin
                    state_d     = PUB;
                    cnt_d       = '0;
                    pulse_vld_d = 1'b1;
                    ch_id_d     = cur_ch_q;
                    pulse_num_d = TIMEOUT_CYC;
                    timeout_d   = 1'b1;
                end
            end
            MEAS: begin
                // falling edge is tested first so it wins over a simultaneous limit hit
                if (!echo_now || cnt_q == tmo) begin
                    state_d     = PUB;
                    cnt_d       = '0;
                    pulse_vld_d = 1'b1;
                    ch_id_d     = cur_ch_q;
                    pulse_num_d = echo_now ? TIMEOUT_CYC : cnt_q[18:0];
                    timeout_d   = echo_now;
                end
            end
            PUB: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: if (cnt_q == GAP_CYC - 22'd1) begin
                state_d  = IDLE;
                cnt_d    = '0;
                cur_ch_d = ~cur_ch_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            echo_m_q    <= '0;
            echo_s_q    <= '0;
            echo_p_q    <= '0;
            cur_ch_q    <= 1'b0;
            cnt_q       <= '0;
            trig_q      <= '0;
            pulse_num_q <= '0;
            pulse_vld_q <= 1'b0;
            ch_id_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_m_q    <= echo;
            echo_s_q    <= echo_m_q;
            echo_p_q    <= echo_s_q;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            pulse_num_q <= pulse_num_d;
            pulse_vld_q <= pulse_vld_d;
            ch_id_q     <= ch_id_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign trig      = trig_q;
    assign pulse_num = pulse_num_q;
    assign pulse_vld = pulse_vld_q;
    assign ch_id     = ch_id_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: randomized ping sequences against a ping-level reference model
// (alternating channel, width within one cycle, timeout on silence/overlong/stuck echo).
module tb_sonar_scheduler;
    localparam int TRIG = 20;
    localparam int TMO  = 400;
    localparam int GAP  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  echo = 2'b00;
    logic [1:0]  trig;
    logic [18:0] pulse_num;
    logic        pulse_vld;
    logic        ch_id;
    logic        timeout;
    logic        busy;

    int   checks = 0;
    int   passes = 0;
    logic exp_ch = 1'b0;

    always #5 clk = ~clk;

    sonar_scheduler #(
        .TRIG_CYC(22'(TRIG)),
        .TIMEOUT_CYC(19'(TMO)),
        .GAP_CYC(22'(GAP))
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
        .pulse_num(pulse_num), .pulse_vld(pulse_vld), .ch_id(ch_id),
        .timeout(timeout), .busy(busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        echo = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({trig, pulse_num, pulse_vld, ch_id, timeout, busy} !== 25'd0)
            $display("FAIL reset_outputs got=%h want=0", {trig, pulse_num, pulse_vld, ch_id, timeout, busy});
        else passes++;
        rst_n = 1'b1;
        exp_ch = 1'b0;
    endtask

    task automatic test_idle();
        int act = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || trig != 2'b00) act++;
        end
        checks++;
        if (act !== 0) $display("FAIL idle_quiet got=%0d active cycles want=0", act);
        else passes++;
    endtask

    // mode 0: echo on selected channel, 1: echo on the other channel, 2: echo stuck high from TRIG
    task automatic ping(input int d, input int w, input int mode, input bit drop);
        int          n, hi, nvld;
        bit          seen, exp_t;
        logic [18:0] num;
        logic        cid, tmo_o, ch;
        ch = exp_ch;
        n = 0;
        seen = 0;
        nvld = 0;
        num = '0;
        cid = 1'b0;
        tmo_o = 1'b0;
        while (trig === 2'b00 && n < GAP + TRIG + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trig !== (ch ? 2'b10 : 2'b01)) $display("FAIL trig_sel got=%b want=%b", trig, ch ? 2'b10 : 2'b01);
        else passes++;
        if (mode == 2) echo[ch] = 1'b1;
        hi = 0;
        while (trig !== 2'b00 && hi < TRIG + 20) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== TRIG) $display("FAIL trig_width got=%0d want=%0d", hi, TRIG);
        else passes++;
        repeat (d) @(negedge clk);
        for (int i = 0; i < w; i++) begin
            if (mode != 2) echo[mode == 1 ? ~ch : ch] = 1'b1;
            @(negedge clk);
            if (drop && i == 20) enable = 1'b0;
            if (pulse_vld) begin
                nvld++;
                if (!seen) begin
                    seen = 1;
                    num = pulse_num;
                    cid = ch_id;
                    tmo_o = timeout;
                end
            end
        end
        echo = 2'b00;
        n = 0;
        while (!seen && n < TMO + 60) begin
            @(negedge clk);
            n++;
            if (pulse_vld) begin
                nvld++;
                seen = 1;
                num = pulse_num;
                cid = ch_id;
                tmo_o = timeout;
            end
        end
        exp_t = (mode != 0) || (w == 0) || (w >= TMO + 10);
        checks++;
        if (nvld !== 1) $display("FAIL strobe_count got=%0d want=1", nvld);
        else passes++;
        checks++;
        if (cid !== ch) $display("FAIL ch_id got=%b want=%b", cid, ch);
        else passes++;
        checks++;
        if (tmo_o !== exp_t) $display("FAIL timeout_flag got=%b want=%b (w=%0d mode=%0d)", tmo_o, exp_t, w, mode);
        else passes++;
        checks++;
        if (exp_t ? (int'(num) != TMO) : (int'(num) < w - 1 || int'(num) > w + 1))
            $display("FAIL pulse_num got=%0d want=%0d (timeout=%b)", num, exp_t ? TMO : w, exp_t);
        else passes++;
        exp_ch = ~exp_ch;
    endtask

    task automatic test_random_pings();
        int r;
        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) ping($urandom_range(0, 40), 0, 0, 0);
            else if (r == 1) ping($urandom_range(0, 40), $urandom_range(TMO + 10, TMO + 40), 0, 0);
            else ping($urandom_range(0, 40), $urandom_range(5, TMO - 10), 0, 0);
        end
    endtask

    task automatic test_boundaries();
        ping(30, 0, 0, 0);
        ping(10, TMO + 30, 0, 0);
        ping(20, 50, 1, 0);
        ping(0, TMO + 40, 2, 0);
    endtask

    task automatic test_enable_drop();
        int n = 0;
        int act = 0;
        ping(10, 100, 0, 1);
        while (busy && n < GAP + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_after_gap got=%b want=0", busy);
        else passes++;
        repeat (50) begin
            @(negedge clk);
            if (trig != 2'b00 || busy) act++;
        end
        checks++;
        if (act !== 0) $display("FAIL stopped_quiet got=%0d active cycles want=0", act);
        else passes++;
        enable = 1'b1;
        ping(5, 60, 0, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int nvld = 0;
        while (trig === 2'b00 && n < GAP + TRIG + 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (trig !== 2'b00 && n < TRIG + 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        echo[exp_ch] = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trig, pulse_num, pulse_vld, ch_id, timeout, busy} !== 25'd0)
            $display("FAIL reset_mid_outputs got=%h want=0", {trig, pulse_num, pulse_vld, ch_id, timeout, busy});
        else passes++;
        repeat (10) begin
            @(negedge clk);
            if (pulse_vld) nvld++;
        end
        echo = 2'b00;
        checks++;
        if (nvld !== 0) $display("FAIL reset_mid_strobe got=%0d want=0", nvld);
        else passes++;
        rst_n = 1'b1;
        exp_ch = 1'b0;
        ping(8, 150, 0, 0);
    endtask

    initial begin
        test_reset();
        test_idle();
        enable = 1'b1;
        ping(200, 300, 0, 0);
        ping(10, 350, 0, 0);
        test_random_pings();
        test_boundaries();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
